cpu_bus_fabric: RTL and testbench

- Parametrised successor to the fixed six-slave CPU data-bus decoder.
- Decodes a registered master strobe against NSLAVE base/mask windows, pulses one slave enable, and waits per slave: either a fixed latency or the slave's own ack.
- Returns read data through a registered mux. Unmapped and timed-out accesses end with a nak.
- Sits between the CPU data bus (stb/we/dm/addr/dout/din) and the peripherals (BIOS memory, VRAMs, IO, SD).

---
 rtl/cpu_bus_pkg.sv | 41 ++++
 rtl/bus_addr_decode.sv | 23 ++
 rtl/cpu_bus_fabric.sv | 145 ++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types, constants and helpers for the CPU data-bus fabric.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } bus_state_t;

    // A per-slave latency of zero means "wait for the slave's own ack".
    localparam logic [3:0] LAT_ACKMODE = 4'd0;

    // Upper bound on slave count; sizes the latency slot helper below.
    localparam int MAX_SLAVE = 16;

    // SWORD system map, for instantiations that want the standard layout.
    localparam logic [31:0] SWORD_BASE_PROG    = 32'h0000_0000;
    localparam logic [31:0] SWORD_BASE_CHARVRAM = 32'h000C_0000;
    localparam logic [31:0] SWORD_BASE_GFXVRAM = 32'h0010_0000;
    localparam logic [31:0] SWORD_BASE_IO      = 32'hBFC0_0000;
    localparam logic [31:0] SWORD_BASE_SDCTRL  = 32'hBFE0_0000;
    localparam logic [31:0] SWORD_BASE_SDDATA  = 32'hBFE1_0000;

    localparam logic [6*32-1:0] SWORD_BASE = {
        SWORD_BASE_SDDATA, SWORD_BASE_SDCTRL, SWORD_BASE_IO,
        SWORD_BASE_GFXVRAM, SWORD_BASE_CHARVRAM, SWORD_BASE_PROG
    };

    localparam logic [6*32-1:0] SWORD_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFC_0000
    };

    // Pull the 4-bit latency of slot 'slot' out of a packed latency vector.
    function automatic logic [3:0] get_lat_slot(input logic [MAX_SLAVE*4-1:0] lat_vec,
                                                input int slot);
        return lat_vec[slot*4 +: 4];
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask window decoder; lowest-index window wins on overlap.
module bus_addr_decode #(
    parameter int NSLAVE = 6,
    parameter int AW = 32,
    parameter logic [NSLAVE*AW-1:0] BASE = '0,
    parameter logic [NSLAVE*AW-1:0] MASK = '0
) (
    input  logic [AW-1:0]     addr,
    output logic [NSLAVE-1:0] hit_onehot,
    output logic              hit
);

    logic [NSLAVE-1:0] raw_hit;

    for (genvar i = 0; i < NSLAVE; i++) begin : g_win
        assign raw_hit[i] = ((addr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]));
    end

    // Isolating the lowest set bit gives the priority winner directly.
    assign hit_onehot = raw_hit & (-raw_hit);
    assign hit = |raw_hit;

endmodule

// File: rtl/cpu_bus_fabric.sv
// CPU data-bus fabric: decodes a master strobe onto NSLAVE windows, pulses one
// slave enable, waits a fixed latency or the slave ack, and returns read data
// with a one-cycle ack (plus nak for unmapped or timed-out accesses).
module cpu_bus_fabric
    import cpu_bus_pkg::*;
#(
    parameter int NSLAVE = 6,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NSLAVE*AW-1:0] BASE = {NSLAVE{32'h0}},
    parameter logic [NSLAVE*AW-1:0] MASK = {NSLAVE{32'hFFFF_0000}},
    parameter logic [NSLAVE*4-1:0]  LAT  = {NSLAVE{4'd1}},
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stbBus,
    input  logic [DW/8-1:0]      weBus,
    input  logic [AW-1:0]        addrBus,
    input  logic [DW-1:0]        dataFromCPU,
    output logic                 ackBus,
    output logic                 nakBus,
    output logic [DW-1:0]        dataToCPU,
    output logic [NSLAVE-1:0]    slaveEN,
    output logic [AW-1:0]        slaveAddr,
    output logic [DW/8-1:0]      slaveWe,
    output logic [DW-1:0]        slaveDin,
    input  logic [NSLAVE*DW-1:0] slaveDout,
    input  logic [NSLAVE-1:0]    ackSlave,
    output logic [AW-1:0]        errAddr,
    output logic                 busy
);

    localparam int IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam logic [MAX_SLAVE*4-1:0] LAT_EXT = (MAX_SLAVE*4)'(LAT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    bus_state_t        state;
    logic [NSLAVE-1:0] hit_onehot;
    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic [IW-1:0]     sel_idx;
    logic [3:0]        sel_lat;
    logic [3:0]        lat_cnt;
    logic [7:0]        tmo_cnt;
    logic [DW-1:0]     sel_rdata;
    logic              sel_ack;
    logic              sel_done;

    bus_addr_decode #(
        .NSLAVE (NSLAVE),
        .AW     (AW),
        .BASE   (BASE),
        .MASK   (MASK)
    ) u_decode (
        .addr       (addrBus),
        .hit_onehot (hit_onehot),
        .hit        (hit)
    );

    // Turn the one-hot winner into a slot index for the muxes below.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (hit_onehot[i]) hit_idx = IW'(i);
        end
    end

    assign sel_lat   = get_lat_slot(LAT_EXT, int'(sel_idx));
    assign sel_rdata = slaveDout[int'(sel_idx)*DW +: DW];
    assign sel_ack   = ackSlave[sel_idx];
    assign sel_done  = (sel_lat == LAT_ACKMODE) ? sel_ack : (lat_cnt == 4'd1);

    // Access sequencer; every bus- and slave-facing output is registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ackBus    <= 1'b0;
            nakBus    <= 1'b0;
            busy      <= 1'b0;
            slaveEN   <= '0;
            dataToCPU <= '0;
            slaveAddr <= '0;
            slaveWe   <= '0;
            slaveDin  <= '0;
            errAddr   <= '0;
            sel_idx   <= '0;
            lat_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stbBus) begin
                        slaveAddr <= addrBus;
                        slaveWe   <= weBus;
                        slaveDin  <= dataFromCPU;
                        busy      <= 1'b1;
                        if (hit) begin
                            slaveEN <= hit_onehot;
                            sel_idx <= hit_idx;
                            state   <= ACCESS;
                        end else begin
                            ackBus    <= 1'b1;
                            nakBus    <= 1'b1;
                            dataToCPU <= '0;
                            errAddr   <= addrBus;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    slaveEN <= '0;
                    lat_cnt <= sel_lat;
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (sel_done) begin
                        dataToCPU <= sel_rdata;
                        ackBus    <= 1'b1;
                        nakBus    <= 1'b0;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        dataToCPU <= '0;
                        ackBus    <= 1'b1;
                        nakBus    <= 1'b1;
                        errAddr   <= slaveAddr;
                        state     <= RESP;
                    end else begin
                        if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    ackBus <= 1'b0;
                    nakBus <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Testbench for cpu_bus_fabric: hand-built vector table, randomized accesses
// against a window/latency reference model, plus timeout and reset sequences.
module tb_cpu_bus_fabric;

    localparam int NS = 6;
    localparam int TMO = 255;
    localparam int CYCLE_LIMIT = 400;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              stbBus = 1'b0;
    logic [3:0]        weBus = '0;
    logic [31:0]       addrBus = '0;
    logic [31:0]       dataFromCPU = '0;
    logic              ackBus;
    logic              nakBus;
    logic [31:0]       dataToCPU;
    logic [NS-1:0]     slaveEN;
    logic [31:0]       slaveAddr;
    logic [3:0]        slaveWe;
    logic [31:0]       slaveDin;
    logic [NS*32-1:0]  slaveDout = '0;
    logic [NS-1:0]     ackSlave = '0;
    logic [31:0]       errAddr;
    logic              busy;

    always #5 clk = ~clk;

    cpu_bus_fabric #(
        .NSLAVE  (NS),
        .AW      (32),
        .DW      (32),
        .BASE    ({32'hBFD0_0000, 32'hBFC0_0000, 32'hBFC0_0000,
                   32'h0010_0000, 32'h000C_0000, 32'h0000_0000}),
        .MASK    ({32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000,
                   32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFC_0000}),
        .LAT     ({4'd0, 4'd4, 4'd0, 4'd8, 4'd2, 4'd1}),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stbBus      (stbBus),
        .weBus       (weBus),
        .addrBus     (addrBus),
        .dataFromCPU (dataFromCPU),
        .ackBus      (ackBus),
        .nakBus      (nakBus),
        .dataToCPU   (dataToCPU),
        .slaveEN     (slaveEN),
        .slaveAddr   (slaveAddr),
        .slaveWe     (slaveWe),
        .slaveDin    (slaveDin),
        .slaveDout   (slaveDout),
        .ackSlave    (ackSlave),
        .errAddr     (errAddr),
        .busy        (busy)
    );

    // Reference memory map (same windows as the DUT parameters above).
    logic [31:0] model_base [NS] = '{32'h0000_0000, 32'h000C_0000, 32'h0010_0000,
                                     32'hBFC0_0000, 32'hBFC0_0000, 32'hBFD0_0000};
    logic [31:0] model_mask [NS] = '{32'hFFFC_0000, 32'hFFFF_0000, 32'hFFF0_0000,
                                     32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000};
    int          model_lat  [NS] = '{1, 2, 8, 0, 4, 0};
    logic [31:0] model_err = '0;

    logic [31:0] slot_data [NS];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          ack_delay;
        bit          hold;
        logic [5:0]  exp_en;
        int          exp_cyc;
        bit          exp_nak;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    int errors = 0;
    int checks = 0;

    int          obs_en_count, obs_en_cycle, obs_ack_cycle, obs_busy_gap, obs_nak_alone;
    logic [5:0]  obs_en_vec;
    logic        obs_nak, obs_busy_after, obs_ack_after;
    logic [31:0] obs_data, obs_saddr, obs_sdin, obs_data_after, obs_err_after;
    logic [3:0]  obs_swe;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    // Which window claims an address, and when/how the access should end.
    task automatic model_access(input logic [31:0] a, input int d,
                                output int idx, output int cyc, output bit nak);
        idx = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((a & model_mask[i]) == (model_base[i] & model_mask[i])) idx = i;
        end
        nak = 1'b0;
        if (idx < 0) begin
            cyc = 1;
            nak = 1'b1;
        end else if (model_lat[idx] != 0) begin
            cyc = 2 + model_lat[idx];
        end else if (d >= 1 && d <= TMO) begin
            cyc = 2 + d;
        end else begin
            cyc = 2 + TMO;
            nak = 1'b1;
        end
    endtask

    // Issue one access from an idle negedge and record what the DUT does,
    // ending on the negedge of the cycle after the ack.
    task automatic apply_stimulus(input logic [31:0] a, input logic [3:0] w,
                                  input logic [31:0] d, input logic [5:0] ack_mask,
                                  input int ack_delay, input bit hold);
        for (int i = 0; i < NS; i++) slaveDout[i*32 +: 32] = slot_data[i];
        addrBus = a;
        weBus = w;
        dataFromCPU = d;
        stbBus = 1'b1;
        obs_en_count = 0;
        obs_en_cycle = -1;
        obs_ack_cycle = -1;
        obs_busy_gap = 0;
        obs_nak_alone = 0;
        obs_en_vec = '0;
        obs_nak = 1'b0;
        obs_data = '0;
        obs_saddr = '0;
        obs_sdin = '0;
        obs_swe = '0;
        for (int n = 1; n <= CYCLE_LIMIT && obs_ack_cycle < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                addrBus = $urandom;
                weBus = 4'($urandom);
                dataFromCPU = $urandom;
                if (!hold) stbBus = 1'b0;
            end
            if (slaveEN != '0) begin
                obs_en_count++;
                obs_en_vec |= slaveEN;
                obs_en_cycle = n;
                obs_saddr = slaveAddr;
                obs_swe = slaveWe;
                obs_sdin = slaveDin;
            end
            if (!busy) obs_busy_gap++;
            if (nakBus && !ackBus) obs_nak_alone++;
            if (ackBus) begin
                obs_ack_cycle = n;
                obs_nak = nakBus;
                obs_data = dataToCPU;
                stbBus = 1'b0;
            end
            ackSlave = 6'($urandom) & ~ack_mask;
            if (ack_delay > 0 && n == 1 + ack_delay) ackSlave = ackSlave | ack_mask;
        end
        @(negedge clk);
        ackSlave = '0;
        stbBus = 1'b0;
        obs_busy_after = busy;
        obs_ack_after = ackBus;
        obs_data_after = dataToCPU;
        obs_err_after = errAddr;
    endtask

    task automatic check_output(input string tag, input logic [31:0] a, input logic [3:0] w,
                                input logic [31:0] d, input logic [5:0] exp_en,
                                input int exp_cyc, input bit exp_nak, input logic [31:0] exp_data);
        if (exp_nak) model_err = a;
        check(tag, "enable pulses", obs_en_count, (exp_en != '0) ? 1 : 0);
        check(tag, "enable vector", 32'(obs_en_vec), 32'(exp_en));
        if (exp_en != '0) begin
            check(tag, "enable cycle", obs_en_cycle, 1);
            check(tag, "slaveAddr", obs_saddr, a);
            check(tag, "slaveWe", 32'(obs_swe), 32'(w));
            check(tag, "slaveDin", obs_sdin, d);
        end
        check(tag, "ack cycle", obs_ack_cycle, exp_cyc);
        check(tag, "nak", 32'(obs_nak), 32'(exp_nak));
        check(tag, "read data", obs_data, exp_data);
        check(tag, "busy gaps", obs_busy_gap, 0);
        check(tag, "nak without ack", obs_nak_alone, 0);
        check(tag, "busy after ack", 32'(obs_busy_after), 32'd0);
        check(tag, "ack width", 32'(obs_ack_after), 32'd0);
        check(tag, "data held", obs_data_after, exp_data);
        check(tag, "errAddr", obs_err_after, model_err);
    endtask

    initial begin
        int idx, cyc, s, dly, ack_seen;
        bit nak, hold;
        logic [31:0] a, d;
        logic [3:0] w;
        logic [5:0] en;

        slot_data = '{32'h1234_5678, 32'h1111_AAAA, 32'h2222_BBBB,
                      32'hCAFE_F00D, 32'h4444_DDDD, 32'h5555_EEEE};

        //          addr           we       wdata          dly hold en         cyc nak  data
        vecs[0] = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 0, 1'b0, 6'b000001, 3,  1'b0, 32'h1234_5678};
        vecs[1] = '{32'hBFC0_1000, 4'b0000, 32'h0000_0000, 5, 1'b0, 6'b001000, 7,  1'b0, 32'hCAFE_F00D};
        vecs[2] = '{32'h7000_0000, 4'b0000, 32'h0000_0000, 0, 1'b0, 6'b000000, 1,  1'b1, 32'h0000_0000};
        vecs[3] = '{32'hBFC0_0004, 4'b0011, 32'hA5A5_0001, 2, 1'b0, 6'b001000, 4,  1'b0, 32'hCAFE_F00D};
        vecs[4] = '{32'h000C_0040, 4'b0000, 32'h0000_0000, 0, 1'b1, 6'b000010, 4,  1'b0, 32'h1111_AAAA};
        vecs[5] = '{32'h0012_3456, 4'b1111, 32'hDEAD_BEEF, 0, 1'b1, 6'b000100, 10, 1'b0, 32'h2222_BBBB};
        vecs[6] = '{32'hBFD0_0008, 4'b0000, 32'h0000_0000, 1, 1'b0, 6'b100000, 3,  1'b0, 32'h5555_EEEE};
        vecs[7] = '{32'h0003_FFFC, 4'b1111, 32'h0BAD_F00D, 0, 1'b0, 6'b000001, 3,  1'b0, 32'h1234_5678};
        vecs[8] = '{32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 0, 1'b1, 6'b000000, 1,  1'b1, 32'h0000_0000};
        vecs[9] = '{32'h0004_0000, 4'b0001, 32'h0000_00FF, 0, 1'b0, 6'b000000, 1,  1'b1, 32'h0000_0000};

        // Reset values.
        repeat (2) @(negedge clk);
        check("reset", "ackBus", 32'(ackBus), 32'd0);
        check("reset", "nakBus", 32'(nakBus), 32'd0);
        check("reset", "busy", 32'(busy), 32'd0);
        check("reset", "slaveEN", 32'(slaveEN), 32'd0);
        check("reset", "dataToCPU", dataToCPU, 32'd0);
        check("reset", "slaveAddr", slaveAddr, 32'd0);
        check("reset", "slaveWe", 32'(slaveWe), 32'd0);
        check("reset", "slaveDin", slaveDin, 32'd0);
        check("reset", "errAddr", errAddr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            apply_stimulus(vecs[v].addr, vecs[v].we, vecs[v].wdata, vecs[v].exp_en,
                           vecs[v].ack_delay, vecs[v].hold);
            check_output($sformatf("vec%0d", v), vecs[v].addr, vecs[v].we, vecs[v].wdata,
                         vecs[v].exp_en, vecs[v].exp_cyc, vecs[v].exp_nak, vecs[v].exp_data);
        end

        // Ack-mode slave that never answers: abandoned after TMO wait cycles.
        apply_stimulus(32'hBFD0_0100, 4'b0000, 32'h0, 6'b100000, 0, 1'b0);
        check_output("timeout", 32'hBFD0_0100, 4'b0000, 32'h0, 6'b100000, 2 + TMO, 1'b1, 32'h0);

        // Reset in the middle of a LAT=8 access.
        for (int i = 0; i < NS; i++) slaveDout[i*32 +: 32] = slot_data[i];
        addrBus = 32'h0010_0000;
        weBus = 4'b0000;
        stbBus = 1'b1;
        repeat (4) begin
            @(negedge clk);
            stbBus = 1'b0;
        end
        rstn = 1'b0;
        #1;
        model_err = '0;
        check("midreset", "ackBus", 32'(ackBus), 32'd0);
        check("midreset", "busy", 32'(busy), 32'd0);
        check("midreset", "slaveEN", 32'(slaveEN), 32'd0);
        check("midreset", "dataToCPU", dataToCPU, 32'd0);
        check("midreset", "slaveAddr", slaveAddr, 32'd0);
        check("midreset", "errAddr", errAddr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        ack_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ackBus || slaveEN != '0) ack_seen++;
        end
        check("midreset", "activity after reset", ack_seen, 0);
        apply_stimulus(vecs[0].addr, vecs[0].we, vecs[0].wdata, vecs[0].exp_en, 0, 1'b0);
        check_output("after-reset", vecs[0].addr, vecs[0].we, vecs[0].wdata,
                     vecs[0].exp_en, vecs[0].exp_cyc, vecs[0].exp_nak, vecs[0].exp_data);

        // Randomized accesses against the reference model.
        for (int r = 0; r < 40; r++) begin
            s = $urandom_range(0, NS);
            if (s == NS) a = $urandom;
            else a = (model_base[s] & model_mask[s]) | ($urandom & ~model_mask[s]);
            w = 4'($urandom);
            d = $urandom;
            for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
            dly = $urandom_range(1, 12);
            hold = 1'($urandom_range(0, 1));
            model_access(a, dly, idx, cyc, nak);
            en = (idx < 0) ? 6'b0 : 6'(1 << idx);
            apply_stimulus(a, w, d, en, dly, hold);
            check_output($sformatf("rand%0d", r), a, w, d, en, cyc, nak,
                         nak ? 32'h0 : slot_data[(idx < 0) ? 0 : idx]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
